// File: rtl/al_npc_ram_partitioned_if.sv
// Bus bundle for the partitioned active-list next-PC RAM: issue-lane writes,
// retire/recovery reads, power-gating controls and the clear/ready pair.
interface al_npc_ram_partitioned_if #(
  parameter int unsigned INDEX        = 6,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NUM_WR_PORTS = 4,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned NUM_PARTS    = 4
);
  logic [NUM_WR_PORTS-1:0][INDEX-1:0] addrWr_i;
  logic [NUM_WR_PORTS-1:0][WIDTH-1:0] dataWr_i;
  logic [NUM_WR_PORTS-1:0]            wrEn_i;
  logic [NUM_WR_PORTS-1:0]            writePortGated_i;
  logic [NUM_RD_PORTS-1:0][INDEX-1:0] addrRd_i;
  logic [NUM_RD_PORTS-1:0][WIDTH-1:0] dataRd_o;
  logic [NUM_RD_PORTS-1:0]            readPortGated_i;
  logic [NUM_PARTS-1:0]               partitionGated_i;
  logic                               clearReq_i;
  logic                               ramReady_o;

  modport master (
    output addrWr_i, dataWr_i, wrEn_i, writePortGated_i, addrRd_i, readPortGated_i,
           partitionGated_i, clearReq_i,
    input  dataRd_o, ramReady_o
  );

  modport slave (
    input  addrWr_i, dataWr_i, wrEn_i, writePortGated_i, addrRd_i, readPortGated_i,
           partitionGated_i, clearReq_i,
    output dataRd_o, ramReady_o
  );
endinterface

// File: rtl/al_npc_ram_partitioned.sv
// Partitioned multi-port active-list next-PC RAM. A row sweep re-initialises every
// newly enabled (or explicitly cleared) partition before ramReady_o is raised.
module al_npc_ram_partitioned #(
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned INDEX        = 6,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NUM_WR_PORTS = 4,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned NUM_PARTS    = 4,
  parameter int unsigned PART_LOG     = 2,
  parameter int unsigned INIT_MODE    = 0,
  parameter int unsigned WR_BYPASS    = 0
) (
  input logic                     clk,
  input logic                     reset,
  al_npc_ram_partitioned_if.slave bus
);
  localparam int unsigned Rows = DEPTH / NUM_PARTS;
  localparam int unsigned RowW = INDEX - PART_LOG;

  typedef enum logic {StClear, StReady} state_e;

  state_e                             state_q, state_d;
  logic [RowW-1:0]                    row_cnt_q, row_cnt_d;
  logic [NUM_PARTS-1:0]               clr_mask_q, clr_mask_d;
  logic [NUM_PARTS-1:0]               part_gated_q;
  logic [NUM_PARTS-1:0]               newly_en;
  logic [NUM_WR_PORTS-1:0]            wr_ok;
  logic [NUM_RD_PORTS-1:0][WIDTH-1:0] rd_data;
  logic [WIDTH-1:0]                   mem_q [NUM_PARTS][Rows];
  logic [WIDTH-1:0]                   mem_d [NUM_PARTS][Rows];

  function automatic logic [PART_LOG-1:0] part_of(input logic [INDEX-1:0] a);
    return a[INDEX-1 -: PART_LOG];
  endfunction

  function automatic logic [RowW-1:0] row_of(input logic [INDEX-1:0] a);
    return a[RowW-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] init_val(input logic [PART_LOG-1:0] p,
                                                input logic [RowW-1:0] r);
    return (INIT_MODE == 1) ? WIDTH'({p, r}) : '0;
  endfunction

  // Falling edge of a gate bit means the partition just powered up with stale contents.
  assign newly_en = part_gated_q & ~bus.partitionGated_i;

  always_comb begin
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      wr_ok[w] = bus.wrEn_i[w] & ~bus.writePortGated_i[w] &
                 ~bus.partitionGated_i[part_of(bus.addrWr_i[w])] & (state_q == StReady);
    end
  end

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    clr_mask_d = clr_mask_q;
    if (state_q == StClear) begin
      row_cnt_d = row_cnt_q + RowW'(1);
      if (row_cnt_q == RowW'(Rows - 1)) begin
        state_d    = StReady;
        row_cnt_d  = '0;
        clr_mask_d = '0;
      end
    end
    if (bus.clearReq_i) begin
      state_d    = StClear;
      row_cnt_d  = '0;
      clr_mask_d = ~bus.partitionGated_i;
    end else if (|newly_en) begin
      state_d    = StClear;
      row_cnt_d  = '0;
      clr_mask_d = clr_mask_q | newly_en;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (state_q == StClear) begin
      for (int unsigned p = 0; p < NUM_PARTS; p++) begin
        if (clr_mask_q[p] && !bus.partitionGated_i[p]) begin
          mem_d[p][row_cnt_q] = init_val(PART_LOG'(p), row_cnt_q);
        end
      end
    end
    // Ascending port order lets the highest-numbered port win a same-address conflict.
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      if (wr_ok[w]) begin
        mem_d[part_of(bus.addrWr_i[w])][row_of(bus.addrWr_i[w])] = bus.dataWr_i[w];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_RD_PORTS; r++) begin
      rd_data[r] = mem_q[part_of(bus.addrRd_i[r])][row_of(bus.addrRd_i[r])];
      if (WR_BYPASS == 1) begin
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
          if (wr_ok[w] && (bus.addrWr_i[w] == bus.addrRd_i[r])) begin
            rd_data[r] = bus.dataWr_i[w];
          end
        end
      end
      if (bus.readPortGated_i[r] || bus.partitionGated_i[part_of(bus.addrRd_i[r])] ||
          (state_q != StReady)) begin
        rd_data[r] = '0;
      end
    end
  end

  assign bus.dataRd_o   = rd_data;
  assign bus.ramReady_o = (state_q == StReady);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StClear;
      row_cnt_q    <= '0;
      clr_mask_q   <= '1;
      part_gated_q <= '0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      clr_mask_q   <= clr_mask_d;
      part_gated_q <= bus.partitionGated_i;
    end
  end

  // Storage is deliberately reset-free; only the sweep gives it defined contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_al_npc_ram_partitioned.sv
// Directed bench: DUT A (sequential init, write bypass) and DUT B (zero init, no bypass)
// share one stimulus stream; each is checked against hand-computed expectations.
module tb_al_npc_ram_partitioned;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  al_npc_ram_partitioned_if #(.INDEX(4), .WIDTH(32), .NUM_WR_PORTS(4), .NUM_RD_PORTS(2),
                              .NUM_PARTS(4)) ifa ();
  al_npc_ram_partitioned_if #(.INDEX(4), .WIDTH(32), .NUM_WR_PORTS(4), .NUM_RD_PORTS(2),
                              .NUM_PARTS(4)) ifb ();

  assign ifb.addrWr_i         = ifa.addrWr_i;
  assign ifb.dataWr_i         = ifa.dataWr_i;
  assign ifb.wrEn_i           = ifa.wrEn_i;
  assign ifb.writePortGated_i = ifa.writePortGated_i;
  assign ifb.addrRd_i         = ifa.addrRd_i;
  assign ifb.readPortGated_i  = ifa.readPortGated_i;
  assign ifb.partitionGated_i = ifa.partitionGated_i;
  assign ifb.clearReq_i       = ifa.clearReq_i;

  al_npc_ram_partitioned #(
    .DEPTH(16), .INDEX(4), .WIDTH(32), .NUM_WR_PORTS(4), .NUM_RD_PORTS(2),
    .NUM_PARTS(4), .PART_LOG(2), .INIT_MODE(1), .WR_BYPASS(1)
  ) u_dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (ifa)
  );

  al_npc_ram_partitioned #(
    .DEPTH(16), .INDEX(4), .WIDTH(32), .NUM_WR_PORTS(4), .NUM_RD_PORTS(2),
    .NUM_PARTS(4), .PART_LOG(2), .INIT_MODE(0), .WR_BYPASS(0)
  ) u_dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       wr_en;
    logic [3:0]       wr_gate;
    logic [3:0][3:0]  wa;
    logic [3:0][31:0] wd;
    logic [3:0]       pgate;
    logic [1:0]       rgate;
    logic [1:0][3:0]  ra;
    logic [1:0][31:0] exp_a;
    logic [1:0][31:0] exp_b;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ready(input string name, input logic exp);
    chk({name, "_a"}, {31'd0, ifa.ramReady_o}, {31'd0, exp});
    chk({name, "_b"}, {31'd0, ifb.ramReady_o}, {31'd0, exp});
  endtask

  task automatic rd_both(input string name, input logic [3:0] addr,
                         input logic [31:0] exp_a, input logic [31:0] exp_b);
    ifa.addrRd_i[0] = addr;
    #1;
    chk({name, "_a"}, ifa.dataRd_o[0], exp_a);
    chk({name, "_b"}, ifb.dataRd_o[0], exp_b);
  endtask

  task automatic apply_vec(input int i);
    step();
    ifa.wrEn_i           = vecs[i].wr_en;
    ifa.writePortGated_i = vecs[i].wr_gate;
    ifa.addrWr_i         = vecs[i].wa;
    ifa.dataWr_i         = vecs[i].wd;
    ifa.partitionGated_i = vecs[i].pgate;
    ifa.readPortGated_i  = vecs[i].rgate;
    ifa.addrRd_i         = vecs[i].ra;
    step();
    ifa.wrEn_i = '0;
    #1;
    for (int r = 0; r < 2; r++) begin
      chk($sformatf("vec%0d_a_rd%0d", i, r), ifa.dataRd_o[r], vecs[i].exp_a[r]);
      chk($sformatf("vec%0d_b_rd%0d", i, r), ifb.dataRd_o[r], vecs[i].exp_b[r]);
    end
    ifa.readPortGated_i = '0;
  endtask

  task automatic write1(input logic [3:0] addr, input logic [31:0] data);
    step();
    ifa.wrEn_i      = 4'b0001;
    ifa.addrWr_i[0] = addr;
    ifa.dataWr_i[0] = data;
    step();
    ifa.wrEn_i = '0;
  endtask

  // Hold clearReq_i across one edge (edge N) and return just after it.
  task automatic pulse_clear();
    step();
    ifa.clearReq_i = 1'b1;
    step();
    ifa.clearReq_i = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    // Write conflict: ports 0 and 3 on addr 5, 0xA vs 0xB.
    vecs[0] = '{wr_en: 4'b1001, wr_gate: 4'b0000, wa: {4'd5, 4'd0, 4'd0, 4'd5},
                wd: {32'hB, 32'h0, 32'h0, 32'hA}, pgate: 4'b0000, rgate: 2'b00,
                ra: {4'd13, 4'd5}, exp_a: {32'd13, 32'hB}, exp_b: {32'd0, 32'hB}};
    // Gated write lane 2 to addr 9 is dropped; lane 1 lands.
    vecs[1] = '{wr_en: 4'b0110, wr_gate: 4'b0100, wa: {4'd0, 4'd9, 4'd2, 4'd0},
                wd: {32'h0, 32'h99, 32'h22, 32'h0}, pgate: 4'b0000, rgate: 2'b00,
                ra: {4'd2, 4'd9}, exp_a: {32'h22, 32'd9}, exp_b: {32'h22, 32'd0}};
    vecs[2] = '{wr_en: 4'b1111, wr_gate: 4'b0000, wa: {4'd15, 4'd14, 4'd3, 4'd0},
                wd: {32'h10F, 32'h10E, 32'h103, 32'h100}, pgate: 4'b0000, rgate: 2'b00,
                ra: {4'd3, 4'd14}, exp_a: {32'h103, 32'h10E}, exp_b: {32'h103, 32'h10E}};
    vecs[3] = '{wr_en: 4'b0000, wr_gate: 4'b0000, wa: '0, wd: '0, pgate: 4'b0000,
                rgate: 2'b01, ra: {4'd15, 4'd14}, exp_a: {32'h10F, 32'h0},
                exp_b: {32'h10F, 32'h0}};
    // Partition 1 gated: write to addr 6 dropped, reads of partition 1 return 0.
    vecs[4] = '{wr_en: 4'b0011, wr_gate: 4'b0000, wa: {4'd0, 4'd0, 4'd0, 4'd6},
                wd: {32'h0, 32'h0, 32'h77, 32'h66}, pgate: 4'b0010, rgate: 2'b00,
                ra: {4'd0, 4'd6}, exp_a: {32'h77, 32'h0}, exp_b: {32'h77, 32'h0}};
    vecs[5] = '{wr_en: 4'b0100, wr_gate: 4'b0000, wa: {4'd0, 4'd5, 4'd0, 4'd0},
                wd: {32'h0, 32'h55, 32'h0, 32'h0}, pgate: 4'b0010, rgate: 2'b00,
                ra: {4'd7, 4'd4}, exp_a: {32'h0, 32'h0}, exp_b: {32'h0, 32'h0}};

    reset                = 1'b0;
    ifa.addrWr_i         = '0;
    ifa.dataWr_i         = '0;
    ifa.wrEn_i           = '0;
    ifa.writePortGated_i = '0;
    ifa.addrRd_i         = '0;
    ifa.readPortGated_i  = '0;
    ifa.partitionGated_i = '0;
    ifa.clearReq_i       = 1'b0;

    // Power-on: held in reset, then ready exactly 4 edges after release.
    step();
    step();
    ifa.addrRd_i[0] = 4'd13;
    #1;
    chk_ready("rst_ready", 1'b0);
    chk("rst_rd_a", ifa.dataRd_o[0], 32'h0);
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_ready($sformatf("pwr_ready_e%0d", k), k == 4);
    end
    rd_both("pwr_rd13", 4'd13, 32'd13, 32'd0);

    // Same-cycle bypass on A only; B still shows the stored value.
    step();
    ifa.wrEn_i   = 4'b1001;
    ifa.addrWr_i = {4'd5, 4'd0, 4'd0, 4'd5};
    ifa.dataWr_i = {32'hB, 32'h0, 32'h0, 32'hA};
    rd_both("bypass_rd5", 4'd5, 32'hB, 32'h0);
    step();
    ifa.wrEn_i = '0;
    rd_both("conflict_rd5", 4'd5, 32'hB, 32'hB);

    for (int i = 0; i < 4; i++) apply_vec(i);
    write1(4'd6, 32'hFF);
    rd_both("wr_ff_rd6", 4'd6, 32'hFF, 32'hFF);
    for (int i = 4; i < 6; i++) apply_vec(i);

    // Re-enable partition 1: re-swept, partition 0 untouched.
    step();
    ifa.partitionGated_i = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_ready($sformatf("reen_ready_e%0d", k), k == 5);
    end
    rd_both("reen_rd6", 4'd6, 32'd6, 32'd0);
    rd_both("reen_rd5", 4'd5, 32'd5, 32'd0);
    rd_both("reen_rd0", 4'd0, 32'h77, 32'h77);
    rd_both("reen_rd3", 4'd3, 32'h103, 32'h103);

    // clearReq_i pulse: low for 4 edges, everything re-initialised.
    pulse_clear();
    chk_ready("clr_ready_e0", 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_ready($sformatf("clr_ready_e%0d", k), k == 4);
    end
    rd_both("clr_rd0", 4'd0, 32'd0, 32'd0);
    rd_both("clr_rd3", 4'd3, 32'd3, 32'd0);

    // Ungate partition 3 at sweep cycle 2: sweep restarts, p3 gets cleared.
    write1(4'd12, 32'hCC);
    rd_both("p3_wr_rd12", 4'd12, 32'hCC, 32'hCC);
    ifa.partitionGated_i = 4'b1000;
    step();
    pulse_clear();
    chk_ready("mid_ready_n0", 1'b0);
    step();
    chk_ready("mid_ready_n1", 1'b0);
    ifa.partitionGated_i = 4'b0000;
    step();
    chk_ready("mid_ready_n2", 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_ready($sformatf("mid_ready_m%0d", k), k == 4);
    end
    rd_both("mid_rd12", 4'd12, 32'd12, 32'd0);

    // Asynchronous reset mid-sweep (row counter already at 2), held across edges.
    pulse_clear();
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    chk_ready("areset_imm", 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_ready($sformatf("areset_hold%0d", k), 1'b0);
    end
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_ready($sformatf("areset_ready_e%0d", k), k == 4);
    end
    for (int a = 0; a < 16; a++) begin
      rd_both($sformatf("final_rd%0d", a), 4'(a), 32'(a), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
